// File: rtl/a2d_sched_pkg.sv
// a2d_sched_pkg: shared types and constants for the A2D round-robin scheduler.
// Holds the FSM state enum, default A2D channel numbers, the command-word
// channel field position and a helper that builds a command word.
package a2d_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        GAP  = 2'd2,
        RD   = 2'd3
    } state_t;

    localparam logic [2:0] DEF_LFT_CH   = 3'd0;
    localparam logic [2:0] DEF_RGHT_CH  = 3'd4;
    localparam logic [2:0] DEF_STEER_CH = 3'd5;
    localparam logic [2:0] DEF_BATT_CH  = 3'd6;
    localparam int         DEF_GAP_CYC  = 2;

    // Channel number sits in cmd[13:11]; everything else in the word is zero.
    localparam int CMD_CH_LSB = 11;
    localparam int GAP_CNT_W  = 4;

    function automatic logic [15:0] makeCmd(input logic [2:0] ch);
        logic [15:0] w_cmd;
        w_cmd = '0;
        w_cmd[CMD_CH_LSB +: 3] = ch;
        return w_cmd;
    endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// a2d_sched_if: link between the A2D scheduler and the SPI monarch.
// The scheduler is the master (issues snd/cmd); the SPI monarch is the slave
// (answers with done/rd_data).
interface a2d_sched_if;
    logic        snd;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (
        output snd,
        output cmd,
        input  done,
        input  rd_data
    );

    modport slave (
        input  snd,
        input  cmd,
        output done,
        output rd_data
    );
endinterface

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin scheduler sharing one SPI monarch between the
// Segway's analog sensors. Each nxt request runs a select transaction, a
// short idle gap, then a read transaction, and stores the 12-bit result in
// the holding register picked by the rotation pointer.
// Build option: define A2D_SCHED_BATT_EN to include the battery channel in
// the rotation; without it the rotation is lft -> rght -> steer and batt
// reads as 12'hFFF.
module a2d_sched
    import a2d_sched_pkg::*;
#(
    parameter logic [2:0] LFT_CH   = DEF_LFT_CH,
    parameter logic [2:0] RGHT_CH  = DEF_RGHT_CH,
    parameter logic [2:0] STEER_CH = DEF_STEER_CH,
    parameter logic [2:0] BATT_CH  = DEF_BATT_CH,
    parameter int         GAP_CYC  = DEF_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              nxt,
    a2d_sched_if.master       spi,
    output logic [11:0]       lft_ld,
    output logic [11:0]       rght_ld,
    output logic [11:0]       steer_pot,
    output logic [11:0]       batt,
    output logic              conv_done,
    output logic              busy
);

`ifdef A2D_SCHED_BATT_EN
    localparam logic [1:0] LAST_PTR = 2'd3;
`else
    localparam logic [1:0] LAST_PTR = 2'd2;
`endif

    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_CYC - 1);

    state_t                 r_state;
    state_t                 w_nextState;
    logic [1:0]             r_ptr;
    logic                   r_pend;
    logic [GAP_CNT_W-1:0]   r_gapCnt;
    logic                   r_snd;
    logic [15:0]            r_cmd;
    logic [11:0]            r_lftLd;
    logic [11:0]            r_rghtLd;
    logic [11:0]            r_steerPot;
    logic                   r_convDone;
    logic                   r_busy;

    logic                   w_start;
    logic                   w_gapLoad;
    logic                   w_sndNext;
    logic                   w_capture;
    logic [2:0]             w_curCh;

    // Map the rotation pointer to its A2D channel number.
    always_comb begin
        w_curCh = LFT_CH;
        case (r_ptr)
            2'd0:    w_curCh = LFT_CH;
            2'd1:    w_curCh = RGHT_CH;
            2'd2:    w_curCh = STEER_CH;
            default: w_curCh = BATT_CH;
        endcase
    end

    // Next-state and one-cycle control strobes for the conversion sequence.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_gapLoad   = 1'b0;
        w_sndNext   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (nxt || r_pend) begin
                    w_start     = 1'b1;
                    w_sndNext   = 1'b1;
                    w_nextState = SEL;
                end
            end
            SEL: begin
                if (spi.done) begin
                    w_gapLoad   = 1'b1;
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_gapCnt == '0) begin
                    w_sndNext   = 1'b1;
                    w_nextState = RD;
                end
            end
            RD: begin
                if (spi.done) begin
                    w_capture   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Registered outputs: snd pulse, command word, busy and conv_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snd      <= 1'b0;
            r_cmd      <= 16'h0000;
            r_busy     <= 1'b0;
            r_convDone <= 1'b0;
        end else begin
            r_snd      <= w_sndNext;
            r_busy     <= (w_nextState != IDLE);
            r_convDone <= w_capture;
            if (w_start) begin
                r_cmd <= makeCmd(w_curCh);
            end
        end
    end

    // Single-entry request queue: a nxt seen while busy is remembered once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= 1'b0;
        end else if (w_start) begin
            r_pend <= 1'b0;
        end else if (nxt && (r_state != IDLE)) begin
            r_pend <= 1'b1;
        end
    end

    // Gap counter: loaded on the select done, counts down to zero in GAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gapCnt <= '0;
        end else if (w_gapLoad) begin
            r_gapCnt <= GAP_LOAD;
        end else if ((r_state == GAP) && (r_gapCnt != '0)) begin
            r_gapCnt <= r_gapCnt - 1'b1;
        end
    end

    // Rotation pointer advances only when a conversion completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (w_capture) begin
            r_ptr <= (r_ptr == LAST_PTR) ? 2'd0 : r_ptr + 2'd1;
        end
    end

    // Result holding registers for the always-present channels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lftLd    <= 12'h000;
            r_rghtLd   <= 12'h000;
            r_steerPot <= 12'h000;
        end else if (w_capture) begin
            case (r_ptr)
                2'd0:    r_lftLd    <= spi.rd_data[11:0];
                2'd1:    r_rghtLd   <= spi.rd_data[11:0];
                2'd2:    r_steerPot <= spi.rd_data[11:0];
                default: ;
            endcase
        end
    end

`ifdef A2D_SCHED_BATT_EN
    logic [11:0] r_batt;

    // Battery holding register, written when the pointer sits on the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_batt <= 12'h000;
        end else if (w_capture && (r_ptr == 2'd3)) begin
            r_batt <= spi.rd_data[11:0];
        end
    end

    assign batt = r_batt;
`else
    assign batt = 12'hFFF;
`endif

    assign spi.snd   = r_snd;
    assign spi.cmd   = r_cmd;
    assign lft_ld    = r_lftLd;
    assign rght_ld   = r_rghtLd;
    assign steer_pot = r_steerPot;
    assign conv_done = r_convDone;
    assign busy      = r_busy;

endmodule
